inversek_result_collector: RTL

Downstream stage of the inversek kinematics pipeline. The core has a fixed latency, no valid signal and cannot stall. This block pairs theta1/theta2 belonging to the same input sample, buffers them in a FIFO, and presents them on a valid/ready stream. It also issues credits upstream so that no sample in flight is ever dropped.

---
 rtl/inversek_pkg.sv | 18 +
 rtl/inversek_sync_fifo.sv | 53 +++++
 rtl/inversek_result_collector.sv | 116 +++++++++++
 3 files changed

// File: rtl/inversek_pkg.sv
// Shared constants and the buffered result record for the inversek result collector.
// Defining INVERSEK_TAG_EN adds a sequence tag field to the record.
package inversek_pkg;
    localparam int BIT_WIDTH  = 32;
    localparam int FRACTIONS  = 15;
    localparam int PIPE_LAT   = 13;
    localparam int THETA2_LAT = 6;
    localparam int RES_DEPTH  = 16;
    localparam int TAG_W      = 8;

    typedef struct packed {
`ifdef INVERSEK_TAG_EN
        logic [TAG_W-1:0]     tag;
`endif
        logic [BIT_WIDTH-1:0] theta1;
        logic [BIT_WIDTH-1:0] theta2;
    } inversek_result_t;
endpackage

// File: rtl/inversek_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// The head word reads as zero while the FIFO is empty.
module inversek_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en_i,
    input  logic [WIDTH-1:0]        wr_data_i,
    input  logic                    rd_en_i,
    output logic [WIDTH-1:0]        rd_data_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    // A write into a full FIFO is accepted only when a read frees the slot this cycle.
    always_comb begin
        do_rd    = rd_en_i && (count_q != '0);
        do_wr    = wr_en_i && ((count_q != FULL_CNT) || do_rd);
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o   = count_q;
endmodule

// File: rtl/inversek_result_collector.sv
// Pairs theta1/theta2 from the fixed-latency inversek core, buffers them and issues credits upstream.
// Optional INVERSEK_TAG_EN adds a per-sample sequence tag on m_tag_o.
module inversek_result_collector
    import inversek_pkg::*;
#(
    parameter int DEPTH = RES_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [BIT_WIDTH-1:0] theta1_i,
    input  logic [BIT_WIDTH-1:0] theta2_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [BIT_WIDTH-1:0] m_theta1_o,
    output logic [BIT_WIDTH-1:0] m_theta2_o,
`ifdef INVERSEK_TAG_EN
    output logic [TAG_W-1:0]     m_tag_o,
`endif
    output logic                 err_o
);
    localparam int DLY   = PIPE_LAT - THETA2_LAT;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_LIM = DEPTH[CNT_W:0];

    logic                 acc, push, pop;
    logic [PIPE_LAT-1:0]  vld_sr_q, vld_sr_d;
    logic [CNT_W-1:0]     inflight_q, inflight_d;
    logic [CNT_W-1:0]     fifo_count;
    logic                 err_q, err_d;
    logic [BIT_WIDTH-1:0] t2_dly_q [DLY];
    inversek_result_t     wr_entry, rd_entry;

    // Credits are derived from registered occupancy only, so a pop frees a credit one cycle later.
    assign s_ready_o = ({1'b0, inflight_q} + {1'b0, fifo_count}) < CREDIT_LIM;

    always_comb begin
        acc        = s_valid_i && s_ready_o;
        push       = vld_sr_q[PIPE_LAT-1];
        vld_sr_d   = {vld_sr_q[PIPE_LAT-2:0], acc};
        inflight_d = inflight_q + CNT_W'(acc) - CNT_W'(push);
        err_d      = err_q || (s_valid_i && !s_ready_o);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr_q   <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            vld_sr_q   <= vld_sr_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // theta2 leaves the core early; delay it until it lines up with theta1 of the same sample.
    always_ff @(posedge clk) begin
        t2_dly_q[0] <= theta2_i;
        for (int i = 1; i < DLY; i++) begin
            t2_dly_q[i] <= t2_dly_q[i-1];
        end
    end

`ifdef INVERSEK_TAG_EN
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] tag_sr_q [PIPE_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= '0;
        end else if (acc) begin
            tag_q <= tag_q + TAG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        tag_sr_q[0] <= tag_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            tag_sr_q[i] <= tag_sr_q[i-1];
        end
    end
`endif

    always_comb begin
        wr_entry        = '0;
        wr_entry.theta1 = theta1_i;
        wr_entry.theta2 = t2_dly_q[DLY-1];
`ifdef INVERSEK_TAG_EN
        wr_entry.tag    = tag_sr_q[PIPE_LAT-1];
`endif
    end

    inversek_sync_fifo #(
        .WIDTH ($bits(inversek_result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push),
        .wr_data_i (wr_entry),
        .rd_en_i   (pop),
        .rd_data_o (rd_entry),
        .count_o   (fifo_count)
    );

    assign m_valid_o  = (fifo_count != '0);
    assign pop        = m_valid_o && m_ready_i;
    assign m_theta1_o = rd_entry.theta1;
    assign m_theta2_o = rd_entry.theta2;
`ifdef INVERSEK_TAG_EN
    assign m_tag_o    = rd_entry.tag;
`endif
    assign err_o      = err_q;
endmodule
